// File: rtl/qcom_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : qcom_cmd_queue
// Brief    : FIFO of op+data commands for the QCOM command port. Each entry is
//            presented over a 4-phase req/ack handshake, one at a time.
//            Optional handshake timeout: QCOM_CMD_QUEUE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module qcom_cmd_queue #(
   parameter int DEPTH_LOG2  = 3,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  c_clk_i,
   input  logic                  c_rst_ni,
   input  logic                  wr_en_i,
   input  logic [3:0]            wr_op_i,
   input  logic [31:0]           wr_dt_i,
   input  logic                  clr_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   cnt_o,
   output logic                  ovf_o,
   output logic                  cmd_req_o,
   input  logic                  cmd_ack_i,
   output logic [3:0]            cmd_op_o,
   output logic [31:0]           cmd_dt_o,
   output logic                  busy_o,
   output logic                  tout_o
);

   localparam int                 C_DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_FULL_CNT = (DEPTH_LOG2 + 1)'(C_DEPTH);

   typedef enum logic [1:0] {
      Q_IDLE = 2'd0,
      Q_REQ  = 2'd1,
      Q_WREL = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [35:0]           r_mem [C_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_cnt;
   logic                  r_ovf;
   logic                  r_req;
   logic [3:0]            r_op;
   logic [31:0]           r_dt;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_tout_hit;

   assign w_full  = (r_cnt == C_FULL_CNT);
   assign w_empty = (r_cnt == '0);
   // fullness is judged on the registered count, so a pop in the same cycle
   // never makes room for a write
   assign w_push  = wr_en_i && !w_full && !clr_i;

   always_ff @(posedge c_clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {wr_op_i, wr_dt_i};
      end
   end

   always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
      if (!c_rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
      end else if (clr_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         if (wr_en_i && w_full) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         Q_IDLE: begin
            if (!w_empty && !cmd_ack_i) begin
               w_pop       = 1'b1;
               w_state_nxt = Q_REQ;
            end
         end
         Q_REQ: begin
            if (cmd_ack_i) begin
               w_state_nxt = Q_WREL;
            end else if (w_tout_hit) begin
               w_state_nxt = Q_IDLE;
            end
         end
         Q_WREL: begin
            // a sync command keeps ack high until QCOM finishes the sync
            if (!cmd_ack_i) begin
               w_state_nxt = Q_IDLE;
            end
         end
         default: w_state_nxt = Q_IDLE;
      endcase
   end

   always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
      if (!c_rst_ni) begin
         r_state <= Q_IDLE;
         r_req   <= 1'b0;
         r_op    <= '0;
         r_dt    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= (w_state_nxt == Q_REQ);
         if (w_pop) begin
            {r_op, r_dt} <= r_mem[r_rd_ptr];
         end
      end
   end

`ifdef QCOM_CMD_QUEUE_TIMEOUT_EN
   logic [15:0] r_tcnt;
   logic        r_tout;

   assign w_tout_hit = (r_tcnt == 16'(TIMEOUT_CYC - 1));

   always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
      if (!c_rst_ni) begin
         r_tcnt <= '0;
         r_tout <= 1'b0;
      end else begin
         r_tcnt <= (r_state == Q_REQ) ? r_tcnt + 16'd1 : 16'd0;
         if (r_state == Q_REQ && !cmd_ack_i && w_tout_hit) begin
            r_tout <= 1'b1;
         end
      end
   end

   assign tout_o = r_tout;
`else
   logic w_unused_tout;

   assign w_unused_tout = (TIMEOUT_CYC == 0);
   assign w_tout_hit    = 1'b0;
   assign tout_o        = 1'b0;
`endif

   assign full_o    = w_full;
   assign empty_o   = w_empty;
   assign cnt_o     = r_cnt;
   assign ovf_o     = r_ovf;
   assign cmd_req_o = r_req;
   assign cmd_op_o  = r_op;
   assign cmd_dt_o  = r_dt;
   assign busy_o    = (r_state != Q_IDLE);

endmodule
`default_nettype wire
